// File: rtl/apb_master_if.sv
// Command/response port plus APB bus signals of the APB requester.
// The master modport is the requester's view; slave is the environment's view.
interface apb_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_slverr;
  logic                  rsp_timeout;
  logic                  psel;
  logic                  penable;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, pready, prdata, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
           psel, penable, paddr, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master.sv
// APB requester: valid/ready commands -> APB SETUP/ACCESS transfers, registered response.
// Optional wait-state abort enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic         pclk,
  input  logic         preset,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t state, state_nxt;
  logic   rdy, accept, done, abort;

  assign rdy           = (state == IDLE) || (state == ACCESS && bus.pready);
  assign accept        = bus.cmd_valid && rdy;
  assign done          = (state == ACCESS) && bus.pready;
  assign bus.cmd_ready = rdy;
  assign bus.psel      = (state != IDLE);
  assign bus.penable   = (state == ACCESS);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] to_cnt;
  logic          rsp_to_q;

  // to_cnt counts completed wait cycles; abort on the cycle that would reach the limit
  assign abort = (state == ACCESS) && !bus.pready && (to_cnt == TO_LAST);

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)                                to_cnt <= '0;
    else if (state == SETUP)                   to_cnt <= '0;
    else if (state == ACCESS && !bus.pready)   to_cnt <= to_cnt + 1'b1;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset)     rsp_to_q <= 1'b0;
    else if (done)  rsp_to_q <= 1'b0;
    else if (abort) rsp_to_q <= 1'b1;
  end

  assign bus.rsp_timeout = rsp_to_q;
`else
  assign abort           = 1'b0;
  assign bus.rsp_timeout = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done)       state_nxt = accept ? SETUP : IDLE;
        else if (abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bus attributes only change on acceptance, so they hold through SETUP/ACCESS and in IDLE
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      bus.paddr  <= '0;
      bus.pwrite <= 1'b0;
      bus.pwdata <= '0;
    end else if (accept) begin
      bus.paddr  <= bus.cmd_addr;
      bus.pwrite <= bus.cmd_write;
      bus.pwdata <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.rsp_slverr <= 1'b0;
    end else begin
      bus.rsp_valid <= done || abort;
      if (done) begin
        bus.rsp_rdata  <= bus.pwrite ? '0 : bus.prdata;
        bus.rsp_slverr <= bus.pslverr;
      end else if (abort) begin
        bus.rsp_rdata  <= '0;
        bus.rsp_slverr <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: zero-wait, wait states, back-to-back, slave error,
// reset mid-transfer, and wait-state timeout (aborting or not depending on the build).
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic pclk = 1'b0;
  logic preset;
  int   errs = 0;
  int   checks = 0;

  apb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock; everything after this is sampled/driven 1ns past the edge
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  initial begin
    preset        = 1'b1;
    cmd(1'b0, 1'b0, 32'h0, 32'h0);
    bus.pready    = 1'b1;
    bus.prdata    = 32'h0;
    bus.pslverr   = 1'b0;
    #2;
    chk("rst_psel",    bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite",  bus.pwrite, 0);
    chk("rst_paddr",   bus.paddr, 0);
    chk("rst_pwdata",  bus.pwdata, 0);
    chk("rst_rsp",     {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 0);
    chk("rst_rdata",   bus.rsp_rdata, 0);
    cyc(); cyc();
    preset = 1'b0;
    #1;
    chk("rst_cmd_ready", bus.cmd_ready, 1);

    // zero-wait write
    cmd(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    cyc();                                   // accepted: SETUP
    cmd(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wr_setup",  {bus.psel, bus.penable}, 2'b10);
    chk("wr_ready0", bus.cmd_ready, 0);
    chk("wr_paddr",  bus.paddr, 32'h10);
    chk("wr_pwdata", bus.pwdata, 32'hDEADBEEF);
    chk("wr_pwrite", bus.pwrite, 1);
    cyc();                                   // ACCESS
    chk("wr_access", {bus.psel, bus.penable}, 2'b11);
    chk("wr_ready1", bus.cmd_ready, 1);
    chk("wr_norsp",  bus.rsp_valid, 0);
    bus.prdata = 32'hFFFF_0000;              // must not leak into a write response
    cyc();                                   // IDLE, response
    chk("wr_idle",   {bus.psel, bus.penable}, 2'b00);
    chk("wr_rsp",    {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b100);
    chk("wr_rdata",  bus.rsp_rdata, 0);
    cyc();
    chk("wr_pulse",  bus.rsp_valid, 0);
    chk("wr_hold_paddr", bus.paddr, 32'h10);

    // read with 3 wait states
    cmd(1'b1, 1'b0, 32'h14, 32'h0);
    bus.pready = 1'b0;
    bus.prdata = 32'hAAAA_AAAA;
    cyc();                                   // SETUP
    cmd(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();                                   // ACCESS wait 1
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_en",    {bus.psel, bus.penable}, 2'b11);
      chk("rd_wait_addr",  bus.paddr, 32'h14);
      chk("rd_wait_ready", bus.cmd_ready, 0);
      chk("rd_wait_rsp",   bus.rsp_valid, 0);
      cyc();
    end
    chk("rd_last_en", bus.penable, 1);
    bus.pready = 1'b1;
    bus.prdata = 32'h12345678;
    cyc();
    bus.prdata = 32'h0;
    chk("rd_rsp",   {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b100);
    chk("rd_rdata", bus.rsp_rdata, 32'h12345678);
    chk("rd_idle",  bus.psel, 0);

    // back-to-back: second command offered while the first is in flight
    cmd(1'b1, 1'b1, 32'h20, 32'h1);
    cyc();                                   // SETUP #1
    cmd(1'b1, 1'b0, 32'h24, 32'h2);
    chk("b2b_s1", {bus.psel, bus.penable}, 2'b10);
    chk("b2b_a1", bus.paddr, 32'h20);
    bus.prdata = 32'h0BAD;
    cyc();                                   // ACCESS #1, second accepted at this edge
    chk("b2b_x1", {bus.psel, bus.penable}, 2'b11);
    chk("b2b_r1", bus.cmd_ready, 1);
    bus.prdata = 32'hCAFE;
    cyc();                                   // SETUP #2, response #1
    cmd(1'b0, 1'b0, 32'h0, 32'h0);
    chk("b2b_s2",    {bus.psel, bus.penable}, 2'b10);
    chk("b2b_a2",    bus.paddr, 32'h24);
    chk("b2b_w2",    bus.pwrite, 0);
    chk("b2b_rsp1",  bus.rsp_valid, 1);
    chk("b2b_rd1",   bus.rsp_rdata, 0);
    cyc();                                   // ACCESS #2
    chk("b2b_x2",    {bus.psel, bus.penable}, 2'b11);
    chk("b2b_gap",   bus.rsp_valid, 0);
    cyc();
    chk("b2b_rsp2",  bus.rsp_valid, 1);
    chk("b2b_rd2",   bus.rsp_rdata, 32'hCAFE);
    chk("b2b_idle",  bus.psel, 0);

    // slave error at completion, after an error pulse during a wait
    cmd(1'b1, 1'b0, 32'h30, 32'h0);
    bus.pready = 1'b0;
    cyc(); cmd(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();                                   // wait cycle with pslverr noise
    bus.pslverr = 1'b1;
    cyc();
    bus.pready = 1'b1; bus.prdata = 32'h55;
    cyc();
    bus.pslverr = 1'b0;
    chk("err_rsp",   {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b110);
    chk("err_rdata", bus.rsp_rdata, 32'h55);

    // pslverr only during wait, clean completion
    cmd(1'b1, 1'b0, 32'h34, 32'h0);
    bus.pready = 1'b0;
    cyc(); cmd(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    bus.pslverr = 1'b1;
    cyc();
    bus.pslverr = 1'b0; bus.pready = 1'b1; bus.prdata = 32'h66;
    cyc();
    chk("noerr_rsp",   {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b100);
    chk("noerr_rdata", bus.rsp_rdata, 32'h66);

    // stuck pready: abort after TO access cycles, or wait forever without the feature
    cmd(1'b1, 1'b0, 32'h38, 32'h0);
    bus.pready = 1'b0; bus.prdata = 32'h77;
    cyc(); cmd(1'b0, 1'b0, 32'h0, 32'h0);
    cyc();                                   // ACCESS cycle 1
`ifdef APB_MASTER_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("to_access", {bus.psel, bus.penable}, 2'b11);
      chk("to_ready",  bus.cmd_ready, 0);
      cyc();
    end
    chk("to_idle",  {bus.psel, bus.penable}, 2'b00);
    chk("to_rsp",   {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b111);
    chk("to_rdata", bus.rsp_rdata, 0);
    bus.pready = 1'b1;
`else
    for (int i = 0; i < 20; i++) cyc();
    chk("stuck_access", {bus.psel, bus.penable}, 2'b11);
    chk("stuck_norsp",  bus.rsp_valid, 0);
    bus.pready = 1'b1;
    cyc();
    chk("stuck_rsp",   {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b100);
    chk("stuck_rdata", bus.rsp_rdata, 32'h77);
`endif
    cyc();

    // reset during an ACCESS wait
    cmd(1'b1, 1'b0, 32'h40, 32'h0);
    bus.pready = 1'b0;
    cyc(); cmd(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(); cyc();
    chk("mr_access", {bus.psel, bus.penable}, 2'b11);
    #2 preset = 1'b1;
    #1;
    chk("mr_drop",  {bus.psel, bus.penable}, 2'b00);
    bus.pready = 1'b1;
    cyc();
    chk("mr_norsp", bus.rsp_valid, 0);
    preset = 1'b0;
    cyc();
    chk("mr_norsp2", bus.rsp_valid, 0);
    cmd(1'b1, 1'b1, 32'h44, 32'h99);
    cyc();
    cmd(1'b0, 1'b0, 32'h0, 32'h0);
    chk("mr_setup", {bus.psel, bus.penable}, 2'b10);
    chk("mr_paddr", bus.paddr, 32'h44);
    cyc();
    chk("mr_access2", {bus.psel, bus.penable}, 2'b11);
    cyc();
    chk("mr_rsp", {bus.rsp_valid, bus.rsp_slverr, bus.rsp_timeout}, 3'b100);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Requester (initiator) end of the team's APB interface: converts a simple valid/ready command port into APB SETUP/ACCESS transfers and returns read data and status on a registered response port. It sits between an internal controller or testbench driver and any APB slave in the design. It supports wait states through `pready`, error reporting through `pslverr`, back-to-back transfers, and an optional wait-state timeout.

## Interface
- `DATA_WIDTH`, 32, width of `pwdata`/`prdata`/command and response data
- `ADDR_WIDTH`, 32, width of `paddr`/`cmd_addr`
- `TIMEOUT_CYCLES`, 15, maximum number of ACCESS cycles with `pready` low before abort (used only with timeout feature); must be ≥1
- `pclk` input 1 APB clock; all logic on rising edge
- `preset` input 1 asynchronous, active-high reset
- `cmd_valid` input 1 command present
- `cmd_ready` output 1 command accepted this cycle when high together with `cmd_valid`
- `cmd_write` input 1 1 = write, 0 = read
- `cmd_addr` input ADDR_WIDTH transfer address
- `cmd_wdata` input DATA_WIDTH write data (ignored for reads)
- `rsp_valid` output 1 one-cycle pulse, transfer finished
- `rsp_rdata` output DATA_WIDTH read data (0 for writes, timeouts)
- `rsp_slverr` output 1 slave error or timeout
- `rsp_timeout` output 1 transfer aborted by timeout
- `psel` output 1 APB select
- `penable` output 1 APB enable
- `paddr` output ADDR_WIDTH APB address
- `pwrite` output 1 APB direction
- `pwdata` output DATA_WIDTH APB write data
- `pready` input 1 slave ready
- `prdata` input DATA_WIDTH slave read data
- `pslverr` input 1 slave error

## Operation
- States: IDLE, SETUP, ACCESS (2-bit registered state).
- `cmd_ready` = (state==IDLE) || (state==ACCESS && `pready`); combinational, no dependence on `cmd_valid`.
- IDLE: `psel`=0, `penable`=0. On `cmd_valid && cmd_ready`: capture `cmd_write/addr/wdata` into `pwrite/paddr/pwdata`, go SETUP.
- SETUP: `psel`=1, `penable`=0; unconditionally go ACCESS next cycle.
- ACCESS: `psel`=1, `penable`=1. Stay while `pready`=0. When `pready`=1: transfer completes; if `cmd_valid` accept new command and go SETUP (back-to-back, `psel` stays 1), else go IDLE.
- `paddr/pwrite/pwdata` stable from SETUP through last ACCESS cycle; hold last values in IDLE.
- Completion: next cycle `rsp_valid`=1 for exactly one cycle; `rsp_rdata` = `prdata` sampled at completion for reads, 0 for writes; `rsp_slverr` = `pslverr` sampled at completion; `rsp_timeout`=0. Response outputs hold values until next response; no backpressure.
- `pslverr`/`prdata` ignored in all cycles except the completion cycle.

## Timing
- Reset (async assert): state IDLE; `psel`, `penable`, `pwrite`, `rsp_valid`, `rsp_slverr`, `rsp_timeout` = 0; `paddr`, `pwdata`, `rsp_rdata` = 0. `cmd_ready`=1 after release.
- Reset mid-transfer: bus drops to IDLE immediately, no response issued for aborted transfer.
- Zero-wait latency: accept at edge N → SETUP cycle N+1 → ACCESS cycle N+2 (`pready`=1) → `rsp_valid` cycle N+3.
- Each wait cycle adds one cycle. Back-to-back throughput: one transfer per 2 cycles.

## Configuration
- `APB_MASTER_TIMEOUT_EN` defined: counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering ACCESS, increments each ACCESS cycle with `pready`=0; when it reaches TIMEOUT_CYCLES with `pready` still 0, transfer aborts: next state IDLE (`psel`/`penable` drop), `cmd_ready` stays 0 that cycle, response with `rsp_timeout`=1, `rsp_slverr`=1, `rsp_rdata`=0. `pready`=1 on the limit cycle completes normally.
- Not defined: no counter; ACCESS waits indefinitely; `rsp_timeout` tied 0.

## Test plan
- Write 0xDEADBEEF to 0x10, `pready`=1 always → SETUP at N+1, ACCESS at N+2 with `paddr`=0x10, `pwdata`=0xDEADBEEF; `rsp_valid` at N+3, `rsp_slverr`=0, `rsp_rdata`=0.
- Read 0x14, slave holds `pready` low 3 ACCESS cycles then returns 0x12345678 → ACCESS lasts 4 cycles, address stable; `rsp_rdata`=0x12345678 one cycle after completion.
- Two commands back-to-back (`cmd_valid` held) → `psel` never drops, pattern SETUP,ACCESS,SETUP,ACCESS; two `rsp_valid` pulses 2 cycles apart.
- Read with `pslverr`=1 at completion → `rsp_slverr`=1, `rsp_timeout`=0; `pslverr` pulses during wait cycles ignored.
- With `APB_MASTER_TIMEOUT_EN`, TIMEOUT_CYCLES=4, `pready` stuck 0 → abort after 4 ACCESS cycles, `rsp_timeout`=1, `rsp_slverr`=1; without macro, bus stays in ACCESS.
- Assert `preset` during ACCESS wait → `psel`/`penable` 0 immediately, no `rsp_valid`; next command runs normally.
